// File: rtl/crc16_pkg.sv
// Shared CRC-16 definitions for the serial transmit and receive stages.
package crc16_pkg;

   localparam int          CRC16_W    = 16;
   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'h0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CRC  = 2'd2,
      DONE = 2'd3
   } chk_state_t;

   // One MSB-first CRC step; no reflection, no final XOR.
   function automatic logic [15:0] crc16_step(
      input logic [15:0] crc,
      input logic        bit_i,
      input logic [15:0] poly = CRC16_POLY
   );
      logic fb;
      fb = crc[15] ^ bit_i;
      return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
   endfunction

endpackage

// File: rtl/crc16_lfsr_bit.sv
// Bit-serial CRC-16 register with clear, load-INIT and step-enable controls.
module crc16_lfsr_bit
   import crc16_pkg::*;
#(
   parameter logic [15:0] POLY = CRC16_POLY,
   parameter logic [15:0] INIT = CRC16_INIT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        load_init,
   input  logic        en,
   input  logic        bit_in,
   output logic [15:0] crc
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   // load_init together with en seeds INIT and folds in the first bit in one cycle.
   always_comb begin
      crc_d = crc_q;
      if (clr) begin
         crc_d = 16'h0000;
      end else if (en) begin
         crc_d = crc16_step(load_init ? INIT : crc_q, bit_in, POLY);
      end else if (load_init) begin
         crc_d = INIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) crc_q <= INIT;
      else     crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/crc16_serial_checker.sv
// Serial CRC-16 frame checker: deserialises DATA_W payload bits plus a 16-bit CRC field.
// Optional macro CRC16_CHK_ERR_CNT_EN adds a saturating bad-frame counter (err_cnt).
//
// state | meaning
// IDLE  | waiting for an accepted bit with sof
// DATA  | shifting payload bits, CRC updating
// CRC   | shifting received CRC field, CRC frozen
// DONE  | one-cycle verdict, frame_done high
module crc16_serial_checker
   import crc16_pkg::*;
#(
   parameter int          DATA_W = 32,
   parameter logic [15:0] POLY   = CRC16_POLY,
   parameter logic [15:0] INIT   = CRC16_INIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sof,
   input  logic              bit_valid,
   input  logic              bit_in,
`ifdef CRC16_CHK_ERR_CNT_EN
   output logic [7:0]        err_cnt,
`endif
   output logic [DATA_W-1:0] data_out,
   output logic [15:0]       crc_rx,
   output logic [15:0]       crc_calc,
   output logic              frame_done,
   output logic              crc_ok,
   output logic              busy,
   output logic              abort
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   chk_state_t        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [3:0]        crc_cnt_q, crc_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [15:0]       crc_sr_q, crc_sr_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [15:0]       crc_rx_q, crc_rx_d;
   logic [15:0]       crc_calc_q, crc_calc_d;
   logic              crc_ok_q, crc_ok_d;
   logic              abort_q, abort_d;
   logic              crc_en, crc_load, start;
   logic [15:0]       crc_cur;

   crc16_lfsr_bit #(
      .POLY (POLY),
      .INIT (INIT)
   ) u_lfsr (
      .clk       (clk),
      .rst       (rst),
      .clr       (1'b0),
      .load_init (crc_load),
      .en        (crc_en),
      .bit_in    (bit_in),
      .crc       (crc_cur)
   );

   assign start = bit_valid & sof;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      crc_cnt_d  = crc_cnt_q;
      shift_d    = shift_q;
      crc_sr_d   = crc_sr_q;
      data_out_d = data_out_q;
      crc_rx_d   = crc_rx_q;
      crc_calc_d = crc_calc_q;
      crc_ok_d   = crc_ok_q;
      abort_d    = 1'b0;
      crc_en     = 1'b0;
      crc_load   = 1'b0;
      // An accepted sof always opens a new frame, whatever the current state.
      if (start) begin
         abort_d   = (state_q == DATA) || (state_q == CRC);
         state_d   = DATA;
         bit_cnt_d = CNT_W'(1);
         crc_cnt_d = 4'd0;
         shift_d   = {{(DATA_W-1){1'b0}}, bit_in};
         crc_sr_d  = 16'h0000;
         crc_en    = 1'b1;
         crc_load  = 1'b1;
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            DATA: begin
               if (bit_valid) begin
                  shift_d = {shift_q[DATA_W-2:0], bit_in};
                  crc_en  = 1'b1;
                  if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                     state_d   = CRC;
                     bit_cnt_d = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
            end
            CRC: begin
               if (bit_valid) begin
                  crc_sr_d = {crc_sr_q[14:0], bit_in};
                  if (crc_cnt_q == 4'd15) begin
                     state_d    = DONE;
                     crc_cnt_d  = 4'd0;
                     data_out_d = shift_q;
                     crc_rx_d   = crc_sr_d;
                     crc_calc_d = crc_cur;
                     crc_ok_d   = (crc_sr_d == crc_cur);
                  end else begin
                     crc_cnt_d = crc_cnt_q + 4'd1;
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         crc_cnt_q  <= 4'd0;
         shift_q    <= '0;
         crc_sr_q   <= 16'h0000;
         data_out_q <= '0;
         crc_rx_q   <= 16'h0000;
         crc_calc_q <= 16'h0000;
         crc_ok_q   <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         crc_cnt_q  <= crc_cnt_d;
         shift_q    <= shift_d;
         crc_sr_q   <= crc_sr_d;
         data_out_q <= data_out_d;
         crc_rx_q   <= crc_rx_d;
         crc_calc_q <= crc_calc_d;
         crc_ok_q   <= crc_ok_d;
         abort_q    <= abort_d;
      end
   end

`ifdef CRC16_CHK_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       frame_bad;

   assign frame_bad = (state_q == CRC) && bit_valid && !sof && (crc_cnt_q == 4'd15) &&
                      ({crc_sr_q[14:0], bit_in} != crc_cur);

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (frame_bad && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) err_cnt_q <= 8'h00;
      else     err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

   assign data_out   = data_out_q;
   assign crc_rx     = crc_rx_q;
   assign crc_calc   = crc_calc_q;
   assign crc_ok     = crc_ok_q;
   assign abort      = abort_q;
   assign frame_done = (state_q == DONE);
   assign busy       = (state_q == DATA) || (state_q == CRC);

endmodule
